// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the RV32I-subset control path.
package cpu_ctrl_pkg;

  // Major opcodes recognised by the control path
  localparam logic [6:0] OpcR  = 7'b0110011;
  localparam logic [6:0] OpcI  = 7'b0010011;
  localparam logic [6:0] OpcLw = 7'b0000011;
  localparam logic [6:0] OpcSw = 7'b0100011;
  localparam logic [6:0] OpcBr = 7'b1100011;

  typedef enum logic [2:0] {
    ClsNone,
    ClsR,
    ClsI,
    ClsLw,
    ClsSw,
    ClsBr
  } op_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  // ALU operation select
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode-to-class decoder, shared with the single-cycle control path.
module op_classify
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OpLen = 7
) (
  input  logic [OpLen-1:0] op_i,
  output op_class_e        cls_o,
  output logic             illegal_o
);

  // Map the major opcode to its class; anything else is illegal
  always_comb begin
    cls_o     = ClsNone;
    illegal_o = 1'b0;
    case (op_i)
      OpLen'(OpcR):  cls_o = ClsR;
      OpLen'(OpcI):  cls_o = ClsI;
      OpLen'(OpcLw): cls_o = ClsLw;
      OpLen'(OpcSw): cls_o = ClsSw;
      OpLen'(OpcBr): cls_o = ClsBr;
      default:       illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer FETCH -> DECODE -> EXEC -> MEM -> WB for the RV32I-subset datapath.
// Optional memory wait timeout is enabled by defining MEM_TIMEOUT_EN.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPLEN          = 7,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OPLEN-1:0] op,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             mem_err,
  output logic             busy
);

  state_e    state_q, state_d;
  op_class_e cls_q, cls_d;
  logic      illegal_q, illegal_d;
  op_class_e dec_cls;
  logic      dec_illegal;
  logic      timeout;

  op_classify #(
    .OpLen(OPLEN)
  ) u_classify (
    .op_i     (op),
    .cls_o    (dec_cls),
    .illegal_o(dec_illegal)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q;
  logic            mem_wait;

  assign mem_wait   = mem_req & ~mem_ready;
  // Limit is hit on the wait cycle that would bring the count to TIMEOUT_CYCLES;
  // a ready in that cycle is not a wait, so the access completes instead.
  assign timeout    = mem_wait && (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign wait_cnt_d = (mem_wait && !timeout) ? wait_cnt_q + CntW'(1) : '0;
  assign mem_err    = mem_err_q;

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (timeout) begin
        mem_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign mem_err            = 1'b0;
`endif

  // Sequencer state, latched op class and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cls_q     <= ClsNone;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; en only matters at instruction boundaries and in IDLE
  always_comb begin
    state_e boundary;
    boundary  = en ? StFetch : StIdle;
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StHalt;
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_illegal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls_q)
          ClsR, ClsI:   state_d = StWb;
          ClsLw, ClsSw: state_d = StMem;
          ClsBr:        state_d = boundary;
          default:      state_d = StHalt;
        endcase
      end
      StMem: begin
        if (mem_ready)    state_d = (cls_q == ClsLw) ? StWb : boundary;
        else if (timeout) state_d = StHalt;
      end
      StWb:    state_d = boundary;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Per-state controls from state and latched class; never from raw op
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = AluAdd;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      StExec: begin
        case (cls_q)
          ClsR: alu_op = AluFunct;
          ClsI: begin
            alu_src = 1'b1;
            alu_op  = AluFunct;
          end
          ClsLw, ClsSw: alu_src = 1'b1;
          ClsBr: begin
            alu_op = AluBranch;
            pc_src = 1'b1;
            pc_we  = alu_zero;
          end
          default: ;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == ClsSw);
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == ClsLw);
      end
      StIdle, StDecode, StHalt: ;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign busy    = (state_q != StIdle) && (state_q != StHalt);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, corner sequences and random
// instructions checked cycle by cycle against a phase-level reference model.
module tb_multicycle_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned ToCycles = 4;
`else
  localparam int unsigned ToCycles = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] op;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, ir_we, pc_we, pc_src, alu_src;
  logic [1:0] alu_op;
  logic       reg_write, mem_to_reg, illegal, mem_err, busy;

  multicycle_ctrl #(
    .OPLEN         (7),
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .op        (op),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .reg_write (reg_write),
    .mem_to_reg(mem_to_reg),
    .illegal   (illegal),
    .mem_err   (mem_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       ir;
    logic       pcw;
    logic       pcs;
    logic       asrc;
    logic [1:0] aop;
    logic       rw;
    logic       m2r;
    logic       ill;
    logic       merr;
    logic       bsy;
  } out_t;

  typedef struct {
    logic       rdy;
    logic       en;
    logic       zero;
    logic [6:0] op;
    out_t       exp;
  } cyc_t;

  typedef struct {
    string      name;
    logic [6:0] opc;
    int         fw;
    int         mw;
    logic       zero;
    logic       en_end;
    int         len;
  } vec_t;

  out_t act;
  assign act = '{req: mem_req, we: mem_we, ir: ir_we, pcw: pc_we, pcs: pc_src,
                 asrc: alu_src, aop: alu_op, rw: reg_write, m2r: mem_to_reg,
                 ill: illegal, merr: mem_err, bsy: busy};

  cyc_t tq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   in_idle  = 1'b1;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  task automatic check(input string name, input out_t got, input out_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_len(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s latency: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push(input logic r, input logic e, input logic z, input logic [6:0] o,
                      input out_t x);
    tq.push_back('{rdy: r, en: e, zero: z, op: o, exp: x});
  endtask

  // Apply queued cycles: inputs just after posedge, outputs sampled at negedge
  task automatic drive(input string name, output int busy_cnt);
    busy_cnt = 0;
    foreach (tq[i]) begin
      mem_ready = tq[i].rdy;
      en        = tq[i].en;
      alu_zero  = tq[i].zero;
      op        = tq[i].op;
      @(negedge clk);
      check($sformatf("%s c%0d", name, i), act, tq[i].exp);
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
    tq.delete();
  endtask

  // Reference model: expected per-cycle controls built phase by phase from the instruction
  task automatic run_instr(input string name, input logic [6:0] opc, input int fw, input int mw,
                           input logic zero, input logic en_end, input int exp_len);
    int   cls;
    int   bc;
    logic r;
    out_t x;
    case (opc)
      7'b0110011: cls = 0;
      7'b0010011: cls = 1;
      7'b0000011: cls = 2;
      7'b0100011: cls = 3;
      7'b1100011: cls = 4;
      default:    cls = 5;
    endcase
    tq.delete();
    if (in_idle) push(rnd(), 1'b1, rnd(), rnd_op(), '0);
    for (int i = 0; i <= fw; i++) begin
      r = (i == fw);
      x = '0; x.req = 1'b1; x.ir = r; x.pcw = r; x.bsy = 1'b1;
      push(r, rnd(), rnd(), rnd_op(), x);
    end
    x = '0; x.bsy = 1'b1;
    push(rnd(), rnd(), rnd(), opc, x);
    if (cls == 5) begin
      x = '0; x.ill = 1'b1;
      push(rnd(), rnd(), rnd(), rnd_op(), x);
    end else begin
      x = '0; x.bsy = 1'b1;
      case (cls)
        0: x.aop = 2'b10;
        1: begin x.aop = 2'b10; x.asrc = 1'b1; end
        2, 3: x.asrc = 1'b1;
        default: begin x.aop = 2'b01; x.pcs = 1'b1; x.pcw = zero; end
      endcase
      push(rnd(), (cls == 4) ? en_end : rnd(), zero, rnd_op(), x);
      if (cls == 2 || cls == 3) begin
        for (int i = 0; i <= mw; i++) begin
          r = (i == mw);
          x = '0; x.req = 1'b1; x.we = (cls == 3); x.bsy = 1'b1;
          push(r, (cls == 3 && r) ? en_end : rnd(), rnd(), rnd_op(), x);
        end
      end
      if (cls <= 2) begin
        x = '0; x.rw = 1'b1; x.m2r = (cls == 2); x.bsy = 1'b1;
        push(rnd(), en_end, rnd(), rnd_op(), x);
      end
    end
    drive(name, bc);
    if (exp_len >= 0) check_len(name, bc, exp_len);
    in_idle = (cls == 5) ? 1'b0 : !en_end;
  endtask

  task automatic hold(input string name, input int n, input out_t x, input logic e);
    int bc;
    for (int i = 0; i < n; i++) push(rnd(), e, rnd(), rnd_op(), x);
    drive(name, bc);
  endtask

  task automatic do_reset(input string name);
    rst_n     = 1'b0;
    en        = 1'b0;
    mem_ready = 1'b0;
    #1;
    check(name, act, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_idle = 1'b1;
  endtask

  vec_t vt[8];
  out_t xo;
  logic [6:0] opc_tab[5];

  initial begin
    vt[0] = '{"r_type",   7'b0110011, 0, 0, 1'b0, 1'b1, 4};
    vt[1] = '{"i_type",   7'b0010011, 1, 0, 1'b0, 1'b1, 5};
    vt[2] = '{"lw_wait3", 7'b0000011, 0, 3, 1'b0, 1'b0, 8};
    vt[3] = '{"sw_zero",  7'b0100011, 0, 0, 1'b0, 1'b1, 4};
    vt[4] = '{"br_taken", 7'b1100011, 0, 0, 1'b1, 1'b1, 3};
    vt[5] = '{"br_not",   7'b1100011, 0, 0, 1'b0, 1'b1, 3};
    vt[6] = '{"sw_w2",    7'b0100011, 2, 1, 1'b0, 1'b0, 7};
    vt[7] = '{"lw_zero",  7'b0000011, 0, 0, 1'b0, 1'b0, 5};
    opc_tab[0] = 7'b0110011;
    opc_tab[1] = 7'b0010011;
    opc_tab[2] = 7'b0000011;
    opc_tab[3] = 7'b0100011;
    opc_tab[4] = 7'b1100011;

    rst_n = 1'b0; en = 1'b0; op = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    #3;
    check("reset", act, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hold("idle_en0", 2, '0, 1'b0);

    foreach (vt[i]) run_instr(vt[i].name, vt[i].opc, vt[i].fw, vt[i].mw, vt[i].zero,
                              vt[i].en_end, vt[i].len);

    // en low through the store still completes the store, then IDLE
    run_instr("sw_en_drop", 7'b0100011, 0, 2, 1'b0, 1'b0, 6);
    hold("after_sw_idle", 2, '0, 1'b0);

    // Reset while fetch is waiting drops mem_req immediately
    en = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    #2;
    xo = '0; xo.req = 1'b1; xo.bsy = 1'b1;
    check("fetch_wait", act, xo);
    do_reset("reset_mid_fetch");

    // Illegal opcode halts until reset
    run_instr("illegal", 7'b1111111, 0, 0, 1'b0, 1'b1, 2);
    xo = '0; xo.ill = 1'b1;
    hold("halt_hold", 4, xo, 1'b1);
    do_reset("reset_clears_halt");

`ifdef MEM_TIMEOUT_EN
    // Ready on the limit cycle wins
    run_instr("to_ready_wins", 7'b0000011, 3, 3, 1'b0, 1'b0, 10);
    push(1'b0, 1'b1, 1'b0, rnd_op(), '0);
    xo = '0; xo.req = 1'b1; xo.bsy = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, rnd(), rnd(), rnd_op(), xo);
    begin
      int bc;
      drive("fetch_timeout", bc);
    end
    xo = '0; xo.merr = 1'b1;
    hold("timeout_halt", 3, xo, 1'b1);
    do_reset("reset_clears_merr");
`endif

    for (int n = 0; n < 60; n++) begin
      run_instr($sformatf("rand%0d", n), opc_tab[$urandom_range(0, 4)],
                $urandom_range(0, 3), $urandom_range(0, 3), rnd(),
                ($urandom_range(0, 3) != 0), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath: FETCH -> DECODE -> EXEC -> MEM -> WB.
- Supplies per-state enables to the PC, instruction register, ALU, register file and the shared instruction/data memory port.
- Opcode class decode is identical to the single-cycle control unit (R, I, LW, SW, BRANCH), but the controls are issued per state rather than per instruction.
- Memory access uses a req/ready handshake.

Parameters:
- OPLEN, 7, opcode width.
- TIMEOUT_CYCLES, 255, memory wait limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; sampled at instruction boundaries.
- op  in  OPLEN  opcode from instruction register; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag; used in EXEC for branches.
- mem_ready  in  1  memory accepts/completes current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request (SW only).
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- alu_src  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  write-back selects memory data.
- illegal  out  1  sticky: unknown opcode decoded.
- mem_err  out  1  sticky: memory timeout.
- busy  out  1  state != IDLE and state != HALT.

Behaviour:
- Reset (async, rst_n low): state = IDLE, op-class register = NONE, timeout counter = 0, illegal = 0, mem_err = 0. All outputs 0 immediately, including mem_req, even mid-handshake.
- Outputs are combinational from state and the registered op class only. No output depends combinationally on op except through that register.
- IDLE: outputs 0. Goes to FETCH when en = 1.
- FETCH: mem_req = 1, mem_we = 0, held stable until mem_ready. On the mem_ready cycle: ir_we = 1, pc_we = 1, pc_src = 0, then go to DECODE.
- DECODE: op is classified and registered.
  - Unknown op -> HALT, illegal <= 1.
  - Otherwise -> EXEC.
- EXEC:
  - R: alu_src = 0, alu_op = 10, then WB.
  - I: alu_src = 1, alu_op = 10, then WB.
  - LW/SW: alu_src = 1, alu_op = 00, then MEM.
  - BRANCH: alu_op = 01, pc_src = 1, pc_we = alu_zero, then the instruction boundary. The datapath holds the old PC for the target.
- MEM: mem_req = 1, mem_we = (SW), alu_op = 00, held until mem_ready.
  - LW -> WB.
  - SW -> instruction boundary.
- WB: reg_write = 1 for exactly one cycle; mem_to_reg = (LW). Then the instruction boundary.
- Instruction boundary: go to FETCH if en = 1, else IDLE. en = 0 mid-instruction never aborts; the current instruction completes.
- HALT: terminal. All outputs 0 except the sticky flags. Left only by reset.
- Latency with zero-wait memory (mem_ready = 1 on request): R/I = 4 cycles, LW = 5, SW = 4, BRANCH = 3.
- Each memory wait cycle adds 1 cycle.
- The mem_req/mem_we pair never changes while mem_req = 1 and mem_ready = 0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter increments each cycle with mem_req = 1 and mem_ready = 0, and clears on mem_ready or a state change.
  - When the count reaches TIMEOUT_CYCLES: mem_req drops, state -> HALT, mem_err <= 1.
  - mem_ready arriving in the same cycle as the limit wins, and the access completes.
- Undefined: no counter; waits indefinitely; mem_err is tied 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (0110011, 0010011, 0000011, 0100011, 1100011);
  - op_class_e {NONE, R, I, LW, SW, BR};
  - state_e {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT};
  - ALUOp encoding constants.
- One sub-module: op_classify, a combinational opcode-to-op_class_e decoder with an illegal output. It is reused by the single-cycle path.

Test Plan:
- Reset, en = 1, R-type op 0110011, mem_ready always 1 -> states FETCH, DECODE, EXEC, WB; reg_write high only in cycle 4, alu_op = 10, alu_src = 0.
- LW, mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_we = 0; WB with mem_to_reg = 1; total 8 cycles.
- BRANCH with alu_zero = 1, then with alu_zero = 0 -> pc_we = 1, pc_src = 1 in EXEC for the first; pc_we = 0 for the second; FETCH follows at cycle 4.
- Op 1111111 -> HALT after DECODE, illegal = 1, busy = 0; only rst_n low clears it.
- en dropped during EXEC of SW -> MEM completes with mem_we = 1, then IDLE; rst_n asserted mid-FETCH -> mem_req drops the same cycle.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mem_ready held 0 in FETCH -> HALT after 4 wait cycles, mem_err = 1.
